seq_event_logger: RTL and testbench
===================================

Name: seq_event_logger

Overview:
- Downstream consumer of the sequence detector's single-cycle detection pulses (detected_0110, detected_0111).
- Time-stamps each detection event and keeps per-pattern saturating counts.
- Buffers event records in a small FIFO, drained by a valid/ready interface toward a host or UART framer.
- Sits between the detector outputs and any readout logic so that no pulse is lost while the consumer is stalled, up to DEPTH events.

Parameters:
- TS_W, 16, timestamp width in bits; free-running cycle counter, wraps modulo 2^TS_W.
- DEPTH, 8, FIFO depth in records; power of two, minimum 2.
- CNT_W, 8, width of each per-pattern event counter; saturating.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- det_a  in  1  pattern-0110 detection pulse, sampled each clk.
- det_b  in  1  pattern-0111 detection pulse, sampled each clk.
- clear  in  1  synchronous clear of counters, overflow flag and timestamp.
- ev_valid  out  1  FIFO head holds a record.
- ev_ready  in  1  consumer accepts the head record when ev_valid && ev_ready.
- ev_type  out  2  head record type: 01 = 0110, 10 = 0111, 11 = both.
- ev_time  out  TS_W  head record timestamp.
- cnt_a  out  CNT_W  number of 0110 events since reset/clear.
- cnt_b  out  CNT_W  number of 0111 events since reset/clear.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky flag: at least one event was dropped.

Behaviour:
- Reset (reset=0, asynchronous): ts=0, FIFO empty, ev_valid=0, ev_type=0, ev_time=0, cnt_a=0, cnt_b=0, level=0, overflow=0.
- Timestamp: ts increments every cycle and wraps from 2^TS_W-1 to 0. When clear=1, ts loads 0 on the next edge.
- Event capture: in any cycle with det_a|det_b=1, build the record {type={det_b,det_a}, time=ts} using the pre-increment ts value and push it.
- Latency: an event sampled at edge N gives ev_valid=1 and the record on ev_type/ev_time after edge N (visible in cycle N+1) if the FIFO was empty.
- Output is FIFO head from registered storage. No combinational path from det_* to ev_*.
- Pop: occurs on a clock edge where ev_valid && ev_ready. ev_* hold stable while ev_valid=1 && ev_ready=0.
- Full with push and no pop: the record is dropped, overflow is set to 1, and FIFO contents are unchanged.
- Full with push and pop in the same cycle: both take effect; the record is accepted, level stays DEPTH, and no overflow.
- Empty with pop: not possible, since ev_valid=0.
- Empty with push: level goes 0 to 1.
- Counters: cnt_a += det_a and cnt_b += det_b, each saturating at 2^CNT_W-1. Counting is independent of FIFO full; dropped events are still counted.
- clear:
  - Zeroes cnt_a, cnt_b, overflow and ts on the next edge.
  - A detection in the clear cycle is not counted, but its record is still pushed with the pre-clear ts.
  - The FIFO is not flushed.
- Reset mid-operation: everything returns to reset values immediately, and queued records are lost.
- Pointers: read/write pointers are $clog2(DEPTH)+1 bits with a wrap bit. full = MSBs differ and LSBs equal; empty = pointers equal.

Optional Feature:
- Macro SEQ_EVENT_LOGGER_DROP_CNT_EN.
- Defined: adds output drop_cnt [CNT_W-1:0], which counts dropped records and saturates at 2^CNT_W-1. It is zeroed by reset and by clear.
- Not defined: the port and its logic are absent; overflow alone reports loss.

Decomposition:
- Package seq_log_pkg:
  - EV_NONE=2'b00, EV_0110=2'b01, EV_0111=2'b10, EV_BOTH=2'b11.
  - Record width constant REC_W = 2 + TS_W, supplied as a function of TS_W.
- Sub-module seq_log_fifo (parameterised REC_W, DEPTH):
  - Synchronous FIFO with push, pop, full, empty and level.
  - Exposes the push-when-full drop indication to the top.

Test Plan:
1. Reset release, then det_a pulse at ts=5 → ev_valid=1 next cycle, ev_type=01, ev_time=5, cnt_a=1, level=1.
2. det_a=det_b=1 in one cycle at ts=12, ev_ready=1 → record type=11, time=12; cnt_a and cnt_b each +1; popped the following edge, level back to 0.
3. ev_ready=0, issue 10 det_b pulses (DEPTH=8) → level=8, overflow=1, cnt_b=10. Then ev_ready=1 → 8 records drain in order with increasing ev_time, then ev_valid=0. With macro defined, drop_cnt=2.
4. FIFO full, ev_ready=1 and det_a in the same cycle → level stays 8, overflow stays 0, new record is last out.
5. Drive det_a 260 times with CNT_W=8 → cnt_a saturates at 255. Pulse clear together with det_a → cnt_a=0 next cycle, and the record is still queued.
6. Assert reset=0 mid-stream with 3 records queued → ev_valid=0, level=0 and all counters 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/seq_log_pkg.sv
// seq_log_pkg: shared definitions for the sequence event logger.
//   ev_type_e : record type codes (bit0 = pattern 0110, bit1 = pattern 0111).
//   rec_w()   : record width for a given timestamp width (type bits + time).
package seq_log_pkg;

  typedef enum logic [1:0] {
    EV_NONE = 2'b00,
    EV_0110 = 2'b01,
    EV_0111 = 2'b10,
    EV_BOTH = 2'b11
  } ev_type_e;

  localparam int TYPE_W = 2;

  function automatic int rec_w(input int ts_w);
    return TYPE_W + ts_w;
  endfunction

endpackage

// File: rtl/seq_log_fifo.sv
// seq_log_fifo: synchronous FIFO of event records.
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   push, wr_data   : write request and record
//   pop             : read request (ignored when empty)
//   rd_data         : head record, read from registered storage
//   full, empty     : occupancy flags
//   level           : occupancy, 0..DEPTH
//   drop            : push refused because full with no simultaneous pop
module seq_log_fifo
  import seq_log_pkg::*;
#(
  parameter int REC_W = 18,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [REC_W-1:0]         wr_data,
  output logic [REC_W-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);

  logic [REC_W-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Pointers carry a wrap bit: equal means empty, only the wrap bit differing means full.
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign do_pop_s  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push_s = push && (!full || do_pop_s);
  assign drop      = push && full && !do_pop_s;
  assign level     = wr_ptr_r - rd_ptr_r;
  assign rd_data   = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
    end
  end

  // Record storage; cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/seq_event_logger.sv
// seq_event_logger: time-stamps detector pulses, counts them per pattern and
// queues {type, time} records for a valid/ready consumer.
// Ports:
//   clk, reset        : clock, asynchronous active-low reset
//   det_a, det_b      : pattern 0110 / 0111 detection pulses
//   clear             : synchronous clear of counters, overflow and timestamp
//   ev_valid/ev_ready : head-record handshake
//   ev_type, ev_time  : head record
//   cnt_a, cnt_b      : saturating per-pattern event counts
//   level             : FIFO occupancy
//   overflow          : sticky record-loss flag
//   drop_cnt          : saturating dropped-record count, present only when
//                       SEQ_EVENT_LOGGER_DROP_CNT_EN is defined
module seq_event_logger
  import seq_log_pkg::*;
#(
  parameter int TS_W  = 16,
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   det_a,
  input  logic                   det_b,
  input  logic                   clear,
  output logic                   ev_valid,
  input  logic                   ev_ready,
  output logic [1:0]             ev_type,
  output logic [TS_W-1:0]        ev_time,
  output logic [CNT_W-1:0]       cnt_a,
  output logic [CNT_W-1:0]       cnt_b,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
`ifdef SEQ_EVENT_LOGGER_DROP_CNT_EN
  ,
  output logic [CNT_W-1:0]       drop_cnt
`endif
);

  localparam int               REC_W   = rec_w(TS_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [TS_W-1:0]  ts_r;
  logic [CNT_W-1:0] cnt_a_r;
  logic [CNT_W-1:0] cnt_b_r;
  logic             overflow_r;
  ev_type_e         rec_type_s;
  logic [REC_W-1:0] rec_s;
  logic [REC_W-1:0] head_s;
  logic             push_s;
  logic             pop_s;
  logic             full_s;
  logic             empty_s;
  logic             drop_s;

  // Record uses the current (pre-increment) timestamp, even in a clear cycle.
  assign rec_type_s = ev_type_e'({det_b, det_a});
  assign rec_s      = {rec_type_s, ts_r};
  assign push_s     = det_a || det_b;
  assign pop_s      = ev_ready && !empty_s;

  seq_log_fifo #(
    .REC_W (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push_s),
    .pop     (pop_s),
    .wr_data (rec_s),
    .rd_data (head_s),
    .full    (full_s),
    .empty   (empty_s),
    .level   (level),
    .drop    (drop_s)
  );

  assign ev_valid = !empty_s;
  assign ev_type  = head_s[REC_W-1:TS_W];
  assign ev_time  = head_s[TS_W-1:0];
  assign cnt_a    = cnt_a_r;
  assign cnt_b    = cnt_b_r;
  assign overflow = overflow_r;

  // Free-running timestamp, reloaded to zero by clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     ts_r <= '0;
    else if (clear) ts_r <= '0;
    else            ts_r <= ts_r + {{(TS_W-1){1'b0}}, 1'b1};
  end

  // Saturating per-pattern counters; dropped events still count, clear-cycle ones do not.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_a_r <= '0;
      cnt_b_r <= '0;
    end else if (clear) begin
      cnt_a_r <= '0;
      cnt_b_r <= '0;
    end else begin
      if (det_a && (cnt_a_r != CNT_MAX)) cnt_a_r <= cnt_a_r + {{(CNT_W-1){1'b0}}, 1'b1};
      if (det_b && (cnt_b_r != CNT_MAX)) cnt_b_r <= cnt_b_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Sticky loss flag; clear takes priority over a drop in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      overflow_r <= 1'b0;
    else if (clear)  overflow_r <= 1'b0;
    else if (drop_s) overflow_r <= 1'b1;
    else             overflow_r <= overflow_r;
  end

`ifdef SEQ_EVENT_LOGGER_DROP_CNT_EN
  logic [CNT_W-1:0] drop_cnt_r;

  // Saturating count of records refused by a full FIFO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                               drop_cnt_r <= '0;
    else if (clear)                           drop_cnt_r <= '0;
    else if (drop_s && (drop_cnt_r != CNT_MAX)) drop_cnt_r <= drop_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    else                                      drop_cnt_r <= drop_cnt_r;
  end

  assign drop_cnt = drop_cnt_r;
`else
  // Without the drop counter, overflow alone reports record loss.
`endif

endmodule

// File: tb/tb_seq_event_logger.sv
// Self-checking bench for seq_event_logger: directed scenarios plus random
// traffic, compared every cycle against a queue-based behavioural model.
module tb_seq_event_logger;

  localparam int TS_W  = 16;
  localparam int DEPTH = 8;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic det_a = 1'b0, det_b = 1'b0, clear = 1'b0, ev_ready = 1'b0;
  logic ev_valid, overflow;
  logic [1:0] ev_type;
  logic [TS_W-1:0] ev_time;
  logic [CNT_W-1:0] cnt_a, cnt_b;
  logic [$clog2(DEPTH):0] level;
`ifdef SEQ_EVENT_LOGGER_DROP_CNT_EN
  logic [CNT_W-1:0] drop_cnt;
`endif

  seq_event_logger #(.TS_W(TS_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .det_a(det_a), .det_b(det_b), .clear(clear),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_type(ev_type), .ev_time(ev_time),
    .cnt_a(cnt_a), .cnt_b(cnt_b), .level(level), .overflow(overflow)
`ifdef SEQ_EVENT_LOGGER_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks_cnt = 0;
  int errors_cnt = 0;

  // Reference model state: records are {type, time} pairs in a queue.
  int m_ts, m_cnt_a, m_cnt_b, m_drops;
  bit m_ovf;
  int q_type[$];
  int q_time[$];

  task automatic check(input string tag, input int got, input int exp);
    checks_cnt++;
    if (got != exp) begin
      errors_cnt++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ts = 0; m_cnt_a = 0; m_cnt_b = 0; m_drops = 0; m_ovf = 0;
    q_type.delete(); q_time.delete();
  endtask

  task automatic model_edge(input bit a, input bit b, input bit clr, input bit rdy);
    bit popped, dropped;
    int t;
    t = m_ts;
    popped = rdy && (q_type.size() > 0);
    dropped = 0;
    if (popped) begin
      void'(q_type.pop_front());
      void'(q_time.pop_front());
    end
    if (a || b) begin
      if (q_type.size() < DEPTH) begin
        q_type.push_back(2 * int'(b) + int'(a));
        q_time.push_back(t);
      end else begin
        dropped = 1;
      end
    end
    if (clr) begin
      m_cnt_a = 0; m_cnt_b = 0; m_ovf = 0; m_drops = 0; m_ts = 0;
    end else begin
      if (a && m_cnt_a < CMAX) m_cnt_a++;
      if (b && m_cnt_b < CMAX) m_cnt_b++;
      if (dropped) begin
        m_ovf = 1;
        if (m_drops < CMAX) m_drops++;
      end
      m_ts = (m_ts + 1) % (1 << TS_W);
    end
  endtask

  task automatic compare_all(input string ph);
    check({ph, "_ev_valid"}, int'(ev_valid), int'(q_type.size() > 0));
    if (q_type.size() > 0) begin
      check({ph, "_ev_type"}, int'(ev_type), q_type[0]);
      check({ph, "_ev_time"}, int'(ev_time), q_time[0]);
    end
    check({ph, "_level"}, int'(level), q_type.size());
    check({ph, "_cnt_a"}, int'(cnt_a), m_cnt_a);
    check({ph, "_cnt_b"}, int'(cnt_b), m_cnt_b);
    check({ph, "_overflow"}, int'(overflow), int'(m_ovf));
`ifdef SEQ_EVENT_LOGGER_DROP_CNT_EN
    check({ph, "_drop_cnt"}, int'(drop_cnt), m_drops);
`endif
  endtask

  task automatic check_reset_vals(input string ph);
    check({ph, "_ev_valid"}, int'(ev_valid), 0);
    check({ph, "_ev_type"}, int'(ev_type), 0);
    check({ph, "_ev_time"}, int'(ev_time), 0);
    check({ph, "_level"}, int'(level), 0);
    check({ph, "_cnt_a"}, int'(cnt_a), 0);
    check({ph, "_cnt_b"}, int'(cnt_b), 0);
    check({ph, "_overflow"}, int'(overflow), 0);
  endtask

  // One clock: drive at negedge, model the edge, compare at the next negedge.
  task automatic cycle(input string ph, input bit a, input bit b, input bit clr, input bit rdy);
    det_a = a; det_b = b; clear = clr; ev_ready = rdy;
    @(posedge clk);
    model_edge(a, b, clr, rdy);
    @(negedge clk);
    compare_all(ph);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b1;

    // Single det_a at ts=5.
    while (m_ts != 5) cycle("t1_idle", 0, 0, 0, 0);
    cycle("t1", 1, 0, 0, 0);
    check("t1_time5", int'(ev_time), 5);

    // Both patterns at ts=12, consumer ready.
    while (m_ts != 12) cycle("t2_idle", 0, 0, 0, 1);
    cycle("t2", 1, 1, 0, 1);
    check("t2_type_both", int'(ev_type), 3);
    cycle("t2_pop", 0, 0, 0, 1);

    // Overfill with consumer stalled, then drain.
    repeat (10) cycle("t3_fill", 0, 1, 0, 0);
    check("t3_level_full", int'(level), DEPTH);
    check("t3_ovf", int'(overflow), 1);
    repeat (9) cycle("t3_drain", 0, 0, 0, 1);

    // Full FIFO with simultaneous push and pop.
    cycle("t4_clr", 0, 0, 1, 0);
    repeat (DEPTH) cycle("t4_fill", 1, 0, 0, 0);
    cycle("t4_pushpop", 1, 0, 0, 1);
    check("t4_no_ovf", int'(overflow), 0);
    repeat (DEPTH + 1) cycle("t4_drain", 0, 0, 0, 1);

    // Counter saturation, then clear coinciding with a detection.
    repeat (260) cycle("t5_sat", 1, 0, 0, 1);
    check("t5_cnt_sat", int'(cnt_a), CMAX);
    cycle("t5_clr", 1, 0, 1, 0);
    check("t5_cnt_zero", int'(cnt_a), 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle("rnd", ($urandom_range(2, 0) == 0), ($urandom_range(2, 0) == 0),
            ($urandom_range(40, 0) == 0), ($urandom_range(1, 0) == 1));
    end

    // Asynchronous reset with records queued.
    cycle("t6_drain", 0, 0, 0, 1);
    repeat (DEPTH) cycle("t6_drain", 0, 0, 0, 1);
    repeat (3) cycle("t6_fill", 1, 1, 0, 0);
    check("t6_level3", int'(level), 3);
    #2;
    reset = 1'b0;
    #1;
    check_reset_vals("t6_async");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    cycle("t6_after", 0, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
